ibex_if_id_skid_stage: RTL and testbench

- Sits directly downstream of the instruction prefetch buffer and registers each fetched instruction into the IF/ID boundary.
- Uses a 2-entry skid buffer: an output register plus one skid register. This makes fetch_ready_o a pure flop output, breaking the combinational ready path from ID back into the prefetch FIFO.
- Classifies each instruction as compressed or uncompressed.
- Resolves the fetch-error / error-plus-2 attribution before ID sees the instruction.

---
 rtl/ibex_if_id_skid_stage.sv | 144 ++++++++++++++
 tb/tb_ibex_if_id_skid_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_if_id_skid_stage.sv
// rtl/ibex_if_id_skid_stage.sv - IF/ID boundary register with one-entry skid buffer
// fetch_ready_o comes straight from a flop so ID's ready never reaches the prefetch FIFO combinationally.
module ibex_if_id_skid_stage #(
  parameter bit ResetData = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  input  logic        fetch_err_plus2_i,
  input  logic        flush_i,
  input  logic        id_ready_i,
  output logic        instr_valid_id_o,
  output logic [31:0] instr_rdata_id_o,
  output logic [15:0] instr_rdata_c_id_o,
  output logic        instr_is_compressed_id_o,
  output logic [31:0] pc_id_o,
  output logic        instr_fetch_err_id_o,
  output logic        instr_fetch_err_plus2_id_o
);

  logic        out_valid_q;
  logic        skid_valid_q;
  logic        ready_q;

  logic [31:0] out_rdata_q;
  logic [31:0] out_addr_q;
  logic        out_err_q;
  logic        out_err_plus2_q;

  logic [31:0] skid_rdata_q;
  logic [31:0] skid_addr_q;
  logic        skid_err_q;
  logic        skid_err_plus2_q;

  logic        accept;
  logic        consume;
  logic        in_compressed;
  logic        in_err;
  logic        in_err_plus2;

  logic        load_out_from_in;
  logic        load_out_from_skid;
  logic        load_skid;
  logic        out_valid_d;
  logic        skid_valid_d;

  assign accept  = fetch_valid_i & ready_q;
  assign consume = out_valid_q & id_ready_i;

  // A compressed instruction never touches the upper halfword, so an error
  // confined there does not apply to it.
  assign in_compressed = (fetch_rdata_i[1:0] != 2'b11);
  assign in_err        = fetch_err_i & ~(fetch_err_plus2_i & in_compressed);
  assign in_err_plus2  = fetch_err_i & fetch_err_plus2_i & ~in_compressed;

  always_comb begin
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    out_valid_d        = out_valid_q;
    skid_valid_d       = skid_valid_q;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        load_out_from_skid = 1'b1;
        skid_valid_d       = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || consume) begin
        load_out_from_in = 1'b1;
        out_valid_d      = 1'b1;
      end else begin
        load_skid    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && ResetData) begin
      out_rdata_q     <= '0;
      out_addr_q      <= '0;
      out_err_q       <= 1'b0;
      out_err_plus2_q <= 1'b0;
    end else if (!rst_i) begin
      if (load_out_from_skid) begin
        out_rdata_q     <= skid_rdata_q;
        out_addr_q      <= skid_addr_q;
        out_err_q       <= skid_err_q;
        out_err_plus2_q <= skid_err_plus2_q;
      end else if (load_out_from_in) begin
        out_rdata_q     <= fetch_rdata_i;
        out_addr_q      <= fetch_addr_i;
        out_err_q       <= in_err;
        out_err_plus2_q <= in_err_plus2;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && ResetData) begin
      skid_rdata_q     <= '0;
      skid_addr_q      <= '0;
      skid_err_q       <= 1'b0;
      skid_err_plus2_q <= 1'b0;
    end else if (!rst_i && load_skid) begin
      skid_rdata_q     <= fetch_rdata_i;
      skid_addr_q      <= fetch_addr_i;
      skid_err_q       <= in_err;
      skid_err_plus2_q <= in_err_plus2;
    end
  end

  assign fetch_ready_o              = ready_q;
  assign instr_valid_id_o           = out_valid_q;
  assign instr_rdata_id_o           = out_rdata_q;
  assign instr_rdata_c_id_o         = out_rdata_q[15:0];
  assign instr_is_compressed_id_o   = (out_rdata_q[1:0] != 2'b11);
  assign pc_id_o                    = out_addr_q;
  assign instr_fetch_err_id_o       = out_err_q;
  assign instr_fetch_err_plus2_id_o = out_err_plus2_q;

endmodule

// File: tb/tb_ibex_if_id_skid_stage.sv
// tb/tb_ibex_if_id_skid_stage.sv - random and directed checks against a queue model of the stage
module tb_ibex_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_rdata;
  logic [31:0] fetch_addr;
  logic        fetch_err;
  logic        fetch_err_plus2;
  logic        flush;
  logic        id_ready;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [15:0] instr_rdata_c;
  logic        instr_is_c;
  logic [31:0] pc_id;
  logic        err_id;
  logic        err_plus2_id;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic        err_plus2;
  } ent_t;

  ent_t model_q[$];

  ibex_if_id_skid_stage #(.ResetData(1'b1)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .fetch_valid_i              (fetch_valid),
    .fetch_ready_o              (fetch_ready),
    .fetch_rdata_i              (fetch_rdata),
    .fetch_addr_i               (fetch_addr),
    .fetch_err_i                (fetch_err),
    .fetch_err_plus2_i          (fetch_err_plus2),
    .flush_i                    (flush),
    .id_ready_i                 (id_ready),
    .instr_valid_id_o           (instr_valid),
    .instr_rdata_id_o           (instr_rdata),
    .instr_rdata_c_id_o         (instr_rdata_c),
    .instr_is_compressed_id_o   (instr_is_c),
    .pc_id_o                    (pc_id),
    .instr_fetch_err_id_o       (err_id),
    .instr_fetch_err_plus2_id_o (err_plus2_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    ent_t h;
    chk("valid", {31'd0, instr_valid}, {31'd0, model_q.size() > 0});
    chk("ready", {31'd0, fetch_ready}, {31'd0, model_q.size() < 2});
    if (model_q.size() > 0) begin
      h = model_q[0];
      chk("rdata", instr_rdata, h.rdata);
      chk("rdata_c", {16'd0, instr_rdata_c}, {16'd0, h.rdata[15:0]});
      chk("is_c", {31'd0, instr_is_c}, {31'd0, h.rdata[1:0] != 2'b11});
      chk("pc", pc_id, h.addr);
      chk("err", {31'd0, err_id}, {31'd0, h.err});
      chk("err_plus2", {31'd0, err_plus2_id}, {31'd0, h.err_plus2});
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, compare after the edge.
  task automatic cyc(input logic v, input logic [31:0] rd, input logic [31:0] ad,
                     input logic e, input logic e2, input logic fl, input logic idr,
                     input logic r);
    ent_t n;
    bit acc, con, c;
    rst = r; fetch_valid = v; fetch_rdata = rd; fetch_addr = ad;
    fetch_err = e; fetch_err_plus2 = e2; flush = fl; id_ready = idr;
    acc = v && (model_q.size() < 2);
    con = (model_q.size() > 0) && idr;
    if (r || fl) begin
      model_q.delete();
    end else begin
      if (con) void'(model_q.pop_front());
      if (acc) begin
        c = (rd[1:0] != 2'b11);
        n.rdata = rd;
        n.addr = ad;
        if (!e) begin
          n.err = 1'b0; n.err_plus2 = 1'b0;
        end else if (!e2) begin
          n.err = 1'b1; n.err_plus2 = 1'b0;
        end else begin
          n.err = !c; n.err_plus2 = !c;
        end
        model_q.push_back(n);
      end
    end
    @(negedge clk);
    compare_model();
  endtask

  task automatic feed(input logic [31:0] ad, input logic idr);
    cyc(1'b1, 32'h0000_0013, ad, 1'b0, 1'b0, 1'b0, idr, 1'b0);
  endtask

  task automatic idle(input logic idr);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, idr, 1'b0);
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_rdata = '0; fetch_addr = '0;
    fetch_err = 1'b0; fetch_err_plus2 = 1'b0; flush = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ready", {31'd0, fetch_ready}, 32'd1);
    chk("rst_pc", pc_id, 32'd0);
    chk("rst_rdata", instr_rdata, 32'd0);

    feed(32'h80, 1'b1);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_pc", pc_id, 32'h80);
    chk("t1_is_c", {31'd0, instr_is_c}, 32'd0);
    chk("t1_err", {30'd0, err_id, err_plus2_id}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      feed(32'h80 + 32'(4 * i), 1'b1);
      chk("t1_stream_pc", pc_id, 32'h80 + 32'(4 * i));
      chk("t1_stream_valid", {31'd0, instr_valid}, 32'd1);
    end
    idle(1'b1);

    feed(32'h100, 1'b0);
    chk("t2_ready_a", {31'd0, fetch_ready}, 32'd1);
    feed(32'h104, 1'b0);
    chk("t2_ready_b", {31'd0, fetch_ready}, 32'd0);
    chk("t2_pc_a", pc_id, 32'h100);
    feed(32'h108, 1'b0);
    chk("t2_pc_hold", pc_id, 32'h100);
    feed(32'h108, 1'b1);
    chk("t2_pc_b", pc_id, 32'h104);
    chk("t2_ready_c", {31'd0, fetch_ready}, 32'd1);
    feed(32'h108, 1'b1);
    chk("t2_pc_c", pc_id, 32'h108);
    idle(1'b1);
    chk("t2_drained", {31'd0, instr_valid}, 32'd0);

    feed(32'h200, 1'b0);
    feed(32'h204, 1'b0);
    cyc(1'b1, 32'h0000_0013, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_ready", {31'd0, fetch_ready}, 32'd1);
    idle(1'b1);
    chk("t3_dropped", {31'd0, instr_valid}, 32'd0);

    cyc(1'b1, 32'h0000_4501, 32'h300, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4a_err", {30'd0, err_id, err_plus2_id}, 32'd0);
    chk("t4a_rdata_c", {16'd0, instr_rdata_c}, 32'h4501);
    chk("t4a_is_c", {31'd0, instr_is_c}, 32'd1);
    cyc(1'b1, 32'hFFFF_FFF3, 32'h302, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4b_err", {30'd0, err_id, err_plus2_id}, 32'd3);
    cyc(1'b1, 32'h0000_4501, 32'h306, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4c_err", {30'd0, err_id, err_plus2_id}, 32'd2);
    idle(1'b1);

    feed(32'h400, 1'b0);
    feed(32'h404, 1'b0);
    cyc(1'b1, 32'h0000_0013, 32'h408, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_ready", {31'd0, fetch_ready}, 32'd1);
    chk("t5_pc", pc_id, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
          $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
